// File: rtl/uart_frame_buffer_pkg.sv
// Shared types and sizing helpers for the UART frame buffer.
package uart_frame_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_e;

  localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;

  function automatic int frame_words(input int input_size, input int time_step);
    return input_size * time_step;
  endfunction

  function automatic int buf_addr_w(input int fw);
    return $clog2(2 * fw);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buffer_if.sv
// UART byte side, LSTM word stream and status flags of the frame buffer.
interface uart_frame_buffer_if #(parameter int D_WL = 24);
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic [7:0]      tx_data;
  logic            tx_en;
  logic            tx_busy;
  logic            req;
  logic            d_o_valid;
  logic [D_WL-1:0] d_o;
  logic            d_o_step_last;
  logic            d_o_frame_last;
  logic            frame_ready;
  logic            overflow;
  logic            timeout_err;
  logic            clr_err;

  modport master (
    output rx_data, rx_valid, tx_busy, req, clr_err,
    input  tx_data, tx_en, d_o_valid, d_o, d_o_step_last, d_o_frame_last,
           frame_ready, overflow, timeout_err
  );

  modport slave (
    input  rx_data, rx_valid, tx_busy, req, clr_err,
    output tx_data, tx_en, d_o_valid, d_o, d_o_step_last, d_o_frame_last,
           frame_ready, overflow, timeout_err
  );
endinterface

// File: rtl/uart_frame_buffer_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
module frame_buffer_ram #(
  parameter int DW    = 24,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/uart_frame_buffer.sv
// Assembles UART bytes into words, buffers whole frames in two banks and
// streams one time step per req.  state | meaning:
//   IDLE  | waiting for a pending req with the read bank full
//   RD    | issuing INPUT_SIZE read addresses
//   DRAIN | last read word on d_o, back to IDLE
module uart_frame_buffer
  import uart_frame_buffer_pkg::*;
#(
  parameter int         D_WL        = 24,
  parameter int         INPUT_SIZE  = 26,
  parameter int         TIME_STEP   = 148,
  parameter int         TIMEOUT_CYC = 200000,
  parameter logic [7:0] ACK_BYTE    = ACK_BYTE_DEF
) (
  input logic                clk,
  input logic                rst_n,
  uart_frame_buffer_if.slave bus
);
  localparam int FRAME_WORDS = frame_words(INPUT_SIZE, TIME_STEP);
  localparam int AW  = buf_addr_w(FRAME_WORDS);
  localparam int NB  = D_WL / 8;
  localparam int BCW = cnt_w(NB);
  localparam int WCW = cnt_w(FRAME_WORDS);
  localparam int RCW = cnt_w(INPUT_SIZE);
  localparam int ICW = cnt_w(TIMEOUT_CYC);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RD    = ST_RD;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;

  logic [D_WL-1:0] r_word;
  logic [BCW-1:0]  r_bcnt;
  logic [WCW-1:0]  r_wcnt;
  logic [ICW-1:0]  r_idle;
  logic            r_we;
  logic            r_load_bank;
  logic [1:0]      r_full;
  logic            r_frame_ready;
  logic            r_ack_pend;
  logic            r_tx_en;
  logic [7:0]      r_tx_data;
  logic            r_ovf;
  logic            r_tmo_err;

  logic [1:0]      r_state;
  logic            r_req_pend;
  logic [RCW-1:0]  r_rcnt;
  logic [WCW-1:0]  r_roff;
  logic            r_read_bank;
  logic            r_dv;
  logic            r_sl;
  logic            r_fl;

  logic [D_WL-1:0] w_word_nxt;
  logic [1:0]      w_full_nxt;
  logic [AW-1:0]   w_waddr;
  logic [AW-1:0]   w_raddr;
  logic [D_WL-1:0] w_rdata;
  logic            w_rx_ok;
  logic            w_ovf;
  logic            w_loaded;
  logic            w_tmo;
  logic            w_complete;
  logic            w_free;
  logic            w_ack_send;
  logic            w_start;
  logic            w_rd;
  logic            w_step_end;
  logic            w_roff_end;

  assign w_rx_ok    = bus.rx_valid & ~r_full[r_load_bank];
  assign w_ovf      = bus.rx_valid &  r_full[r_load_bank];
  assign w_loaded   = (r_bcnt != '0) | (r_wcnt != '0);
  assign w_tmo      = ~bus.rx_valid & ~r_we & w_loaded & (r_idle == ICW'(TIMEOUT_CYC - 1));
  assign w_complete = r_we & (r_wcnt == WCW'(FRAME_WORDS - 1));
  assign w_free     = r_dv & r_fl;
  assign w_ack_send = r_ack_pend & ~bus.tx_busy;

  assign w_start    = (r_state == S_IDLE) & r_req_pend & r_full[r_read_bank];
  assign w_rd       = (r_state == S_RD);
  assign w_step_end = (r_rcnt == RCW'(INPUT_SIZE - 1));
  assign w_roff_end = (r_roff == WCW'(FRAME_WORDS - 1));

  // Bank base is FRAME_WORDS, not a power of two, so the memory stays 2*FRAME_WORDS deep.
  assign w_waddr = r_load_bank ? AW'(FRAME_WORDS) + AW'(r_wcnt) : AW'(r_wcnt);
  assign w_raddr = r_read_bank ? AW'(FRAME_WORDS) + AW'(r_roff) : AW'(r_roff);

  always_comb begin
    w_word_nxt = r_word >> 8;
    w_word_nxt[D_WL-1 -: 8] = bus.rx_data;
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_complete) w_full_nxt[r_load_bank] = 1'b1;
    if (w_free)     w_full_nxt[r_read_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word      <= '0;
      r_bcnt      <= '0;
      r_wcnt      <= '0;
      r_idle      <= '0;
      r_we        <= 1'b0;
      r_load_bank <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_rx_ok) begin
        r_word <= w_word_nxt;
        if (r_bcnt == BCW'(NB - 1)) begin
          r_bcnt <= '0;
          r_we   <= 1'b1;
        end else begin
          r_bcnt <= r_bcnt + BCW'(1);
        end
      end
      if (r_we) begin
        if (w_complete) begin
          r_wcnt      <= '0;
          r_load_bank <= ~r_load_bank;
        end else begin
          r_wcnt <= r_wcnt + WCW'(1);
        end
      end else if (w_tmo) begin
        r_wcnt <= '0;
        r_bcnt <= '0;
      end
      if (bus.rx_valid || !w_loaded || w_tmo) r_idle <= '0;
      else                                    r_idle <= r_idle + ICW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full        <= 2'b00;
      r_frame_ready <= 1'b0;
      r_ack_pend    <= 1'b0;
      r_tx_en       <= 1'b0;
      r_tx_data     <= 8'h00;
      r_ovf         <= 1'b0;
      r_tmo_err     <= 1'b0;
    end else begin
      r_full        <= w_full_nxt;
      r_frame_ready <= |w_full_nxt;
      r_ack_pend    <= w_complete | (r_ack_pend & ~w_ack_send);
      r_tx_en       <= w_ack_send;
      if (w_ack_send) r_tx_data <= ACK_BYTE;
      r_ovf         <= w_ovf | (r_ovf & ~bus.clr_err);
      r_tmo_err     <= w_tmo | (r_tmo_err & ~bus.clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_pend  <= 1'b0;
      r_rcnt      <= '0;
      r_roff      <= '0;
      r_read_bank <= 1'b0;
      r_dv        <= 1'b0;
      r_sl        <= 1'b0;
      r_fl        <= 1'b0;
    end else begin
      r_req_pend <= bus.req | (r_req_pend & ~w_start);
      r_dv       <= w_rd;
      r_sl       <= w_rd & w_step_end;
      r_fl       <= w_rd & w_step_end & w_roff_end;
      if (w_free) r_read_bank <= ~r_read_bank;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_RD;
            r_rcnt  <= '0;
          end
        end
        S_RD: begin
          r_rcnt <= r_rcnt + RCW'(1);
          r_roff <= w_roff_end ? '0 : r_roff + WCW'(1);
          if (w_step_end) r_state <= S_DRAIN;
        end
        S_DRAIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  frame_buffer_ram #(
    .DW    (D_WL),
    .DEPTH (2 * FRAME_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (r_we),
    .i_waddr (w_waddr),
    .i_wdata (r_word),
    .i_re    (w_rd),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign bus.d_o            = r_dv ? w_rdata : '0;
  assign bus.d_o_valid      = r_dv;
  assign bus.d_o_step_last  = r_sl;
  assign bus.d_o_frame_last = r_fl;
  assign bus.tx_en          = r_tx_en;
  assign bus.tx_data        = r_tx_data;
  assign bus.frame_ready    = r_frame_ready;
  assign bus.overflow       = r_ovf;
  assign bus.timeout_err    = r_tmo_err;
endmodule

// File: tb/tb_uart_frame_buffer.sv
// Bench for uart_frame_buffer with 16-bit words, 2 words/step, 2 steps/frame.
`timescale 1ns/1ps
module tb_uart_frame_buffer;
  localparam int D_WL = 16, INPUT_SIZE = 2, TIME_STEP = 2, TMO = 40;
  localparam int FW = INPUT_SIZE * TIME_STEP;
  localparam int NRAND = 6;

  typedef struct { logic [15:0] w; logic sl; logic fl; int cyc; } cap_t;
  typedef struct { logic [7:0][7:0] b; logic [3:0][15:0] w; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_buffer_if #(.D_WL(D_WL)) bus();

  uart_frame_buffer #(
    .D_WL(D_WL), .INPUT_SIZE(INPUT_SIZE), .TIME_STEP(TIME_STEP),
    .TIMEOUT_CYC(TMO), .ACK_BYTE(8'hA5)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int req_cyc = 0;
  logic [7:0] last_tx = 8'h00;
  cap_t cap_q[$];
  cap_t exp_q[$];
  vec_t vecs[3];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.d_o_valid) cap_q.push_back('{bus.d_o, bus.d_o_step_last, bus.d_o_frame_last, cyc});
    if (bus.tx_en) begin
      ack_cnt++;
      last_tx = bus.tx_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input logic clr);
    @(negedge clk);
    bus.rx_data = b; bus.rx_valid = 1'b1; bus.clr_err = clr;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.clr_err = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0][7:0] b, input int maxgap);
    for (int i = 0; i < 8; i++) send_byte(b[i], 1 + $urandom_range(0, maxgap), 1'b0);
  endtask

  task automatic pulse_req();
    @(negedge clk); bus.req = 1'b1;
    @(negedge clk); bus.req = 1'b0;
    req_cyc = cyc;
  endtask

  task automatic pulse_clr();
    @(negedge clk); bus.clr_err = 1'b1;
    @(negedge clk); bus.clr_err = 1'b0;
  endtask

  task automatic wait_caps(input int n, input string name);
    int k = 0;
    while (cap_q.size() < n && k < 100) begin
      @(negedge clk); #1; k++;
    end
    if (cap_q.size() < n) check({name, " words timeout"}, cap_q.size(), n);
  endtask

  task automatic expect_step(input string name, input logic [15:0] w0, input logic [15:0] w1,
                             input logic fl);
    cap_t a, b;
    wait_caps(2, name);
    if (cap_q.size() >= 2) begin
      a = cap_q.pop_front();
      b = cap_q.pop_front();
      check({name, " word0"}, a.w, w0);
      check({name, " word1"}, b.w, w1);
      check({name, " step_last0"}, a.sl, 0);
      check({name, " step_last1"}, b.sl, 1);
      check({name, " frame_last0"}, a.fl, 0);
      check({name, " frame_last1"}, b.fl, fl);
      check({name, " latency"}, a.cyc - req_cyc, 2);
      check({name, " no gap"}, b.cyc - a.cyc, 1);
    end
  endtask

  // Reference: word k = byte 2k + 256 * byte 2k+1; step/frame marks from position.
  task automatic model_push(input logic [7:0][7:0] b);
    cap_t c;
    for (int k = 0; k < FW; k++) begin
      c.w   = 16'(b[2*k]) + 16'(b[2*k+1]) * 16'd256;
      c.sl  = (k % INPUT_SIZE) == INPUT_SIZE - 1;
      c.fl  = (k == FW - 1);
      c.cyc = 0;
      exp_q.push_back(c);
    end
  endtask

  task automatic stream_frame();
    int tgt;
    for (int s = 0; s < TIME_STEP; s++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      tgt = cap_q.size() + INPUT_SIZE;
      pulse_req();
      wait_caps(tgt, "stream");
    end
  endtask

  task automatic compare_caps(input string name);
    cap_t a, e;
    check({name, " word count"}, cap_q.size(), exp_q.size());
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      a = cap_q.pop_front();
      e = exp_q.pop_front();
      check({name, " word"}, a.w, e.w);
      check({name, " step_last"}, a.sl, e.sl);
      check({name, " frame_last"}, a.fl, e.fl);
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [63:0] rand_frame();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  initial begin
    int a0, k;
    logic [63:0] fa, fb;

    vecs[0].b = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    vecs[0].w = {16'h0807, 16'h0605, 16'h0403, 16'h0201};
    vecs[1].b = {8'h34, 8'h12, 8'hFF, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    vecs[1].w = {16'h3412, 16'hFF00, 16'hEFBE, 16'hADDE};
    vecs[2].b = {8'hFE, 8'h7F, 8'h01, 8'h80, 8'h00, 8'h00, 8'hFF, 8'hFF};
    vecs[2].w = {16'hFE7F, 16'h0180, 16'h0000, 16'hFFFF};

    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_busy = 1'b0;
    bus.req = 1'b0; bus.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst d_o_valid", bus.d_o_valid, 0);
    check("rst d_o", bus.d_o, 0);
    check("rst tx_en", bus.tx_en, 0);
    check("rst tx_data", bus.tx_data, 0);
    check("rst frame_ready", bus.frame_ready, 0);
    check("rst overflow", bus.overflow, 0);
    check("rst timeout_err", bus.timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed frames, alternating banks
    for (int i = 0; i < 3; i++) begin
      a0 = ack_cnt;
      send_frame(vecs[i].b, 0);
      repeat (5) @(negedge clk); #1;
      check("load ack count", ack_cnt - a0, 1);
      check("load ack byte", last_tx, 8'hA5);
      check("load frame_ready", bus.frame_ready, 1);
      pulse_req();
      expect_step("load step0", vecs[i].w[0], vecs[i].w[1], 1'b0);
      pulse_req();
      expect_step("load step1", vecs[i].w[2], vecs[i].w[3], 1'b1);
      @(negedge clk); #1;
      check("frame_ready after frame", bus.frame_ready, 0);
    end
    repeat (TMO + 10) @(negedge clk);
    check("empty loader no timeout", bus.timeout_err, 0);
    check("no overflow after loads", bus.overflow, 0);

    // Timeout discards a partial frame
    send_byte(8'h11, 2, 1'b0);
    send_byte(8'h22, 2, 1'b0);
    send_byte(8'h33, 2, 1'b0);
    repeat (TMO - 10) @(negedge clk);
    check("timeout not early", bus.timeout_err, 0);
    repeat (15) @(negedge clk);
    check("timeout_err set", bus.timeout_err, 1);
    check("timeout frame_ready", bus.frame_ready, 0);
    pulse_clr();
    check("timeout_err cleared", bus.timeout_err, 0);
    send_frame(vecs[1].b, 0);
    repeat (5) @(negedge clk);
    pulse_req();
    expect_step("resync step0", vecs[1].w[0], vecs[1].w[1], 1'b0);
    pulse_req();
    expect_step("resync step1", vecs[1].w[2], vecs[1].w[3], 1'b1);

    // ACK held off by a busy transmitter
    bus.tx_busy = 1'b1;
    a0 = ack_cnt;
    send_frame(vecs[2].b, 1);
    repeat (10) @(negedge clk); #1;
    check("busy ack held", ack_cnt - a0, 0);
    bus.tx_busy = 1'b0;
    repeat (6) @(negedge clk); #1;
    check("busy ack released", ack_cnt - a0, 1);
    repeat (10) @(negedge clk); #1;
    check("busy ack once", ack_cnt - a0, 1);
    check("busy ack byte", last_tx, 8'hA5);
    pulse_req();
    expect_step("busy step0", vecs[2].w[0], vecs[2].w[1], 1'b0);
    pulse_req();
    expect_step("busy step1", vecs[2].w[2], vecs[2].w[3], 1'b1);

    // Overflow with both banks full
    cap_q.delete(); exp_q.delete();
    fa = rand_frame(); fb = rand_frame();
    model_push(fa); model_push(fb);
    send_frame(fa, 1);
    send_frame(fb, 1);
    repeat (5) @(negedge clk);
    check("two frames no overflow", bus.overflow, 0);
    check("two frames ready", bus.frame_ready, 1);
    send_byte(8'h5A, 2, 1'b0);
    check("overflow set", bus.overflow, 1);
    pulse_clr();
    check("overflow cleared", bus.overflow, 0);
    send_byte(8'hC3, 2, 1'b1);
    check("overflow wins over clr", bus.overflow, 1);
    pulse_clr();
    check("overflow cleared again", bus.overflow, 0);
    stream_frame();
    stream_frame();
    compare_caps("overflow data");

    // Randomised ping-pong: next frame loads while the current one streams
    a0 = ack_cnt;
    fa = rand_frame();
    model_push(fa);
    send_frame(fa, 3);
    for (int f = 1; f <= NRAND; f++) begin
      fb = rand_frame();
      if (f < NRAND) model_push(fb);
      fork
        begin if (f < NRAND) send_frame(fb, 3); end
        begin stream_frame(); end
      join
    end
    repeat (5) @(negedge clk); #1;
    compare_caps("pingpong");
    check("pingpong ack count", ack_cnt - a0, NRAND);
    check("pingpong no overflow", bus.overflow, 0);

    // Reset during the second word of a step
    send_frame(vecs[0].b, 0);
    repeat (5) @(negedge clk);
    pulse_req();
    k = 0;
    while (!bus.d_o_valid && k < 20) begin
      @(negedge clk); #1; k++;
    end
    check("midstream first word", bus.d_o_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("mid rst d_o_valid", bus.d_o_valid, 0);
    check("mid rst d_o", bus.d_o, 0);
    check("mid rst step_last", bus.d_o_step_last, 0);
    check("mid rst frame_last", bus.d_o_frame_last, 0);
    check("mid rst frame_ready", bus.frame_ready, 0);
    check("mid rst tx_en", bus.tx_en, 0);
    check("mid rst tx_data", bus.tx_data, 0);
    check("mid rst overflow", bus.overflow, 0);
    check("mid rst timeout_err", bus.timeout_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cap_q.delete();
    pulse_req();
    repeat (15) @(negedge clk); #1;
    check("req ignored when empty", cap_q.size(), 0);
    check("empty after reset", bus.frame_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
